button_event_decoder: RTL

- Consumer end of the debounced button line: takes the clean level `bt` from the debouncer and turns it into single-cycle event pulses (press, release, short press, long press, auto-repeat).
- Sits between each button debouncer and the stopwatch control FSM, e.g. start/stop on short press, lap/reset on long press.
- One instance per button.

---
 rtl/btn_evt_pkg.sv | 24 ++
 rtl/btn_hold_timer.sv | 34 +++
 rtl/button_event_decoder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event decoder.
// BTN_EVT_REPEAT_EN (optional, undefined by default) enables auto-repeat in
// button_event_decoder.
package btn_evt_pkg;

  // Decoder FSM states.
  // ARM:  waiting for the button to be released after reset.
  // IDLE: ready for a new press.
  // HELD: pressed, hold time not yet long.
  // LONG: pressed past the long threshold.
  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    HELD = 2'd2,
    LONG = 2'd3
  } btn_state_t;

  // Convert a duration in milliseconds into clock cycles.
  function automatic int unsigned ms_to_ticks(input int unsigned clk_hz,
                                              input int unsigned ms);
    return clk_hz / 1000 * ms;
  endfunction

endpackage

// File: rtl/btn_hold_timer.sv
// Loadable down-counter with enable and terminal-count pulse.
// load has priority over en. While en is high the counter decrements, stops
// at zero, and raises tc for every enabled cycle spent at zero.
module btn_hold_timer #(
  parameter int          WIDTH    = 4,
  parameter int unsigned LOAD_VAL = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] LOAD_V = WIDTH'(LOAD_VAL);

  logic [WIDTH-1:0] count;

  // Counter register: load, decrement while enabled, hold at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_V;
    end else if (en && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign tc = en && (count == '0);

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced button level into single-cycle
// press / release / short / long / auto-repeat pulses plus a held level.
// All outputs are registered; reset is synchronous and active-high.
// The release pulse is named release_evt because "release" is a
// SystemVerilog keyword.
// Optional macro BTN_EVT_REPEAT_EN: when defined, repeat_evt pulses every
// TICKS_REP cycles after long_press; when undefined, repeat_evt is tied 0.
module button_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic bt,
  output logic press,
  output logic release_evt,
  output logic short_press,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam int unsigned TICKS_LONG = ms_to_ticks(CLK_HZ, LONG_MS);
  localparam int unsigned TICKS_REP  = ms_to_ticks(CLK_HZ, REPEAT_MS);
  localparam int          W_LONG     = (TICKS_LONG < 2) ? 1 : $clog2(TICKS_LONG);

  if (TICKS_LONG < 2) begin : g_bad_long
    $error("button_event_decoder: TICKS_LONG must be >= 2");
  end
  if (TICKS_REP < 2) begin : g_bad_rep
    $error("button_event_decoder: TICKS_REP must be >= 2");
  end

  btn_state_t state;

  logic hold_load;
  logic hold_en;
  logic hold_tc;

  // Hold timer is armed on the press edge and runs only while HELD; it
  // reaches zero after TICKS_LONG-1 decrements, so the long edge lands
  // exactly TICKS_LONG cycles after the press edge.
  assign hold_load = (state == IDLE) && bt;
  assign hold_en   = (state == HELD);

  btn_hold_timer #(
    .WIDTH    (W_LONG),
    .LOAD_VAL (TICKS_LONG - 1)
  ) u_hold_timer (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .en   (hold_en),
    .tc   (hold_tc)
  );

`ifdef BTN_EVT_REPEAT_EN
  localparam int W_REP = $clog2(TICKS_REP);

  logic rep_load;
  logic rep_en;
  logic rep_tc;

  // Repeat timer starts on the long edge and reloads on every pulse.
  assign rep_load = ((state == HELD) && bt && hold_tc) || rep_tc;
  assign rep_en   = (state == LONG);

  btn_hold_timer #(
    .WIDTH    (W_REP),
    .LOAD_VAL (TICKS_REP - 1)
  ) u_rep_timer (
    .clk  (clk),
    .rst  (rst),
    .load (rep_load),
    .en   (rep_en),
    .tc   (rep_tc)
  );

  // Repeat pulse register; a release on the same edge suppresses it.
  always_ff @(posedge clk) begin
    if (rst) begin
      repeat_evt <= 1'b0;
    end else begin
      repeat_evt <= (state == LONG) && bt && rep_tc;
    end
  end
`else
  assign repeat_evt = 1'b0;
`endif

  // Main FSM with registered event outputs; pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      held        <= 1'b0;
    end else begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
      case (state)
        ARM: begin
          if (!bt) state <= IDLE;
        end
        IDLE: begin
          if (bt) begin
            state <= HELD;
            press <= 1'b1;
            held  <= 1'b1;
          end
        end
        HELD: begin
          if (!bt) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            short_press <= 1'b1;
            held        <= 1'b0;
          end else if (hold_tc) begin
            state      <= LONG;
            long_press <= 1'b1;
          end
        end
        LONG: begin
          if (!bt) begin
            state       <= IDLE;
            release_evt <= 1'b1;
            held        <= 1'b0;
          end
        end
        default: begin
          state <= ARM;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule
